// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with flush/branch redirect and branch capture across stalls.
// Optional PC_GEN_FETCH_COUNT_EN adds an accepted-fetch counter on fetch_count.
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic        pending_o,
    output logic [31:0] fetch_count
);
    logic        pend_valid;
    logic [31:0] pend_target;
    assign pending_o = pend_valid;
    // ce_o low for one cycle after reset so the reset vector is fetched before any increment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o        <= RESET_VECTOR;
            ce_o        <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (!ce_o) begin
            ce_o <= 1'b1;
        end else if (flush) begin
            pc_o       <= flush_pc;
            pend_valid <= 1'b0;
        end else if (stall) begin
            if (branch_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target;
            end
        end else if (branch_valid) begin
            pc_o       <= branch_target;
            pend_valid <= 1'b0;
        end else if (pend_valid) begin
            pc_o       <= pend_target;
            pend_valid <= 1'b0;
        end else begin
            pc_o <= pc_o + PC_STEP;
        end
    end
`ifdef PC_GEN_FETCH_COUNT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (ce_o && !stall) cnt <= cnt + 32'd1;
    end
    assign fetch_count = cnt;
`else
    assign fetch_count = 32'h0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen against a next-PC rule model.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        pending_o;
    logic [31:0] fetch_count;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .pc_o(pc_o), .ce_o(ce_o), .pending_o(pending_o), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_pc = RV;
    logic        m_ce = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_cnt = '0;

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] fp,
                        input logic b, input logic [31:0] bt);
        @(negedge clk);
        rst = r; stall = s; flush = f; flush_pc = fp; branch_valid = b; branch_target = bt;
        if (r) begin
            m_pc = RV; m_ce = 1'b0; m_pend = 1'b0; m_cnt = 32'd0;
        end else begin
`ifdef PC_GEN_FETCH_COUNT_EN
            if (m_ce && !s) m_cnt = m_cnt + 32'd1;
`endif
            if (!m_ce) m_ce = 1'b1;
            else if (f) begin m_pc = fp; m_pend = 1'b0; end
            else if (s) begin
                if (b) begin m_pend = 1'b1; m_tgt = bt; end
            end
            else if (b) begin m_pc = bt; m_pend = 1'b0; end
            else if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; end
            else m_pc = m_pc + 32'd4;
        end
        q.push_back('{m_pc, m_ce, m_pend, m_cnt});
        @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("ce_o", {31'd0, ce_o}, {31'd0, e.ce});
                chk("pending_o", {31'd0, pending_o}, {31'd0, e.pend});
                chk("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h8000_1000);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h8000_2000);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h8000_2000);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'hBFC0_0380, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h8000_0180, 1, 32'h8000_3000);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h8000_4000);
        step(0, 1, 0, 0, 1, 32'h8000_5000);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h8000_6000);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC)) : $urandom();
            step($urandom_range(99, 0) < 2, $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6,
                 $urandom(), $urandom_range(99, 0) < 25, t);
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator feeding the instruction-fetch stage: it owns the architectural fetch PC and drives the fetch address and fetch enable into ifetch. It computes the next PC from sequential increment, a branch/jump target resolved in ID, or a flush redirect (exception entry / ERET) from CP0. A branch that arrives while the front end is stalled is captured and applied when the stall releases, so no redirect is lost.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC loaded on reset
- PC_STEP, 4, sequential increment in bytes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  IF hold from pipeline control (includes ifetch stall); PC must not advance
- flush  in  1  redirect to flush_pc; highest priority, overrides stall
- flush_pc  in  32  exception vector or EPC/ErrorEPC target
- branch_valid  in  1  single-cycle pulse from ID: taken branch/jump resolved
- branch_target  in  32  target address accompanying branch_valid
- pc_o  out  32  current fetch address (ifetch `addr`)
- ce_o  out  1  fetch enable; 0 means pc_o is not a real fetch
- pending_o  out  1  a captured branch is waiting for stall release
- fetch_count  out  32  accepted-fetch counter (see Configuration)

## Operation
- State: pc (32), ce (1), pend_valid (1), pend_target (32), fetch counter (32).
- Next-PC priority, evaluated each cycle when ce=1:
  1. flush=1: pc <= flush_pc; pend_valid <= 0. Applies even if stall=1.
  2. stall=1: pc holds; if branch_valid, pend_valid <= 1, pend_target <= branch_target.
  3. branch_valid=1: pc <= branch_target; pend_valid <= 0.
  4. pend_valid=1: pc <= pend_target; pend_valid <= 0.
  5. otherwise pc <= pc + PC_STEP (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
- branch_valid with pend_valid already set: newer target overwrites (branch in delay slot is architecturally unpredictable; defined here as last-wins).
- No alignment checking; misaligned targets pass through unchanged (ifetch raises AdEL).
- Delay slot: ID asserts branch_valid while IF holds the delay-slot PC; the redirect takes effect on the following accepted cycle, so the delay slot is fetched exactly once.

## Timing
- Reset (rst=1 at edge): pc=RESET_VECTOR, ce=0, pend_valid=0, pending_o=0, fetch_count=0.
- First cycle after reset release: ce=1, pc stays RESET_VECTOR (not incremented while ce was 0).
- pc_o, ce_o, pending_o are registered outputs; no combinational input-to-output path.
- Redirect latency: flush or branch_valid at edge N -> pc_o = target after edge N (visible cycle N+1).
- Captured branch: applied at first edge with stall=0; pending_o high from the cycle after capture until that edge.
- rst asserted mid-stall with pend_valid=1: pending discarded, reset values apply.
- flush and branch_valid same cycle: flush wins, branch dropped.

## Configuration
- Macro `PC_GEN_FETCH_COUNT_EN`.
- Defined: fetch_count increments by 1 on each edge with ce=1, stall=0, rst=0 (including flush/branch cycles); wraps at 2^32.
- Undefined: counter register absent, fetch_count tied to 32'h0.

## Test plan
- Reset release, stall=0 for 4 cycles -> ce_o 0 then 1; pc_o BFC00000, BFC00000, BFC00004, BFC00008.
- At pc BFC00010, branch_valid with target 80001000, stall=0 -> next pc_o 80001000, then 80001004.
- stall=1 for 3 cycles, branch_valid pulse (target 80002000) in 1st stalled cycle -> pc_o held, pending_o=1; after stall drops, pc_o=80002000, pending_o=0.
- Pending branch 80002000 held, flush=1 with flush_pc BFC00380 while stall=1 -> pc_o=BFC00380, pending_o=0, branch never taken.
- flush and branch_valid same cycle (flush_pc 80000180, target 80003000) -> pc_o=80000180.
- pc at FFFFFFFC, stall=0 -> wraps to 00000000; with macro defined, fetch_count equals count of unstalled ce=1 cycles (e.g. 10 after 10 such cycles, unchanged across stalls).
